dual_port_snoopy_cache_unit: RTL and testbench



---
 rtl/dual_port_snoopy_cache_unit.sv | 137 +++++++++++++
 tb/tb_dual_port_snoopy_cache_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_snoopy_cache_unit.sv
// Set-associative cache storage with a processor port and a snoop port.
// Holds tags, coherence states, per-set LRU ages and line data. A snoop state
// write that lands on the same set/way as a processor tag/state write
// overrides it and raises cpuConflict so the controller can retry.
module dual_port_snoopy_cache_unit #(
  parameter int unsigned TAG_WIDTH         = 6,
  parameter int unsigned INDEX_WIDTH       = 6,
  parameter int unsigned OFFSET_WIDTH      = 4,
  parameter int unsigned SET_ASSOCIATIVITY = 2,
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned STATE_WIDTH       = 2,
  parameter int unsigned INVALID_STATE     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [INDEX_WIDTH-1:0]       cpuIndex,
  input  logic [OFFSET_WIDTH-1:0]      cpuOffset,
  input  logic [TAG_WIDTH-1:0]         cpuTagIn,
  input  logic                         cpuAccessEnable,
  input  logic [DATA_WIDTH-1:0]        cpuDataIn,
  input  logic                         cpuWriteData,
  input  logic [STATE_WIDTH-1:0]       cpuStateIn,
  input  logic                         cpuWriteState,
  input  logic                         cpuWriteTag,
  output logic                         cpuHit,
  output logic [SET_ASSOCIATIVITY-1:0] cpuCacheNumber,
  output logic [DATA_WIDTH-1:0]        cpuDataOut,
  output logic [STATE_WIDTH-1:0]       cpuStateOut,
  output logic                         cpuConflict,
  input  logic [INDEX_WIDTH-1:0]       snoopIndex,
  input  logic [TAG_WIDTH-1:0]         snoopTagIn,
  input  logic [STATE_WIDTH-1:0]       snoopStateIn,
  input  logic                         snoopWriteState,
  output logic                         snoopHit,
  output logic [SET_ASSOCIATIVITY-1:0] snoopCacheNumber,
  output logic [STATE_WIDTH-1:0]       snoopStateOut
);

  localparam int unsigned WAYS  = 1 << SET_ASSOCIATIVITY;
  localparam int unsigned SETS  = 1 << INDEX_WIDTH;
  localparam int unsigned WORDS = 1 << OFFSET_WIDTH;
  localparam logic [STATE_WIDTH-1:0]       INV    = STATE_WIDTH'(INVALID_STATE);
  localparam logic [SET_ASSOCIATIVITY-1:0] OLDEST = SET_ASSOCIATIVITY'(WAYS - 1);

  logic [TAG_WIDTH-1:0]         tag_q   [SETS][WAYS];
  logic [STATE_WIDTH-1:0]       state_q [SETS][WAYS];
  logic [SET_ASSOCIATIVITY-1:0] age_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0]        data_q  [SETS][WAYS][WORDS];

  logic                         cpu_hit_c, snoop_hit_c, has_inv_c;
  logic [SET_ASSOCIATIVITY-1:0] cpu_hit_way_c, inv_way_c, old_way_c, cpu_way_c, snoop_way_c;
  logic [SET_ASSOCIATIVITY-1:0] acc_age_c;
  logic                         snoop_we_c, conflict_c, lru_en_c;

  // Tag match, victim choice and collision detection; lowest matching way wins.
  always_comb begin
    cpu_hit_c     = 1'b0;
    cpu_hit_way_c = '0;
    snoop_hit_c   = 1'b0;
    snoop_way_c   = '0;
    has_inv_c     = 1'b0;
    inv_way_c     = '0;
    old_way_c     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (state_q[cpuIndex][w] != INV && tag_q[cpuIndex][w] == cpuTagIn) begin
        cpu_hit_c     = 1'b1;
        cpu_hit_way_c = SET_ASSOCIATIVITY'(w);
      end
      if (state_q[snoopIndex][w] != INV && tag_q[snoopIndex][w] == snoopTagIn) begin
        snoop_hit_c = 1'b1;
        snoop_way_c = SET_ASSOCIATIVITY'(w);
      end
      if (state_q[cpuIndex][w] == INV) begin
        has_inv_c = 1'b1;
        inv_way_c = SET_ASSOCIATIVITY'(w);
      end
      if (age_q[cpuIndex][w] == OLDEST) begin
        old_way_c = SET_ASSOCIATIVITY'(w);
      end
    end
    cpu_way_c  = cpu_hit_c ? cpu_hit_way_c : (has_inv_c ? inv_way_c : old_way_c);
    acc_age_c  = age_q[cpuIndex][cpu_way_c];
    snoop_we_c = snoopWriteState && snoop_hit_c;
    conflict_c = snoop_we_c && (cpuWriteState || cpuWriteTag) &&
                 (cpuIndex == snoopIndex) && (cpu_way_c == snoop_way_c);
    lru_en_c   = cpuAccessEnable && (cpu_hit_c || cpuWriteTag);
  end

  // Port outputs read straight from storage.
  always_comb begin
    cpuHit           = cpu_hit_c;
    cpuCacheNumber   = cpu_way_c;
    cpuDataOut       = data_q[cpuIndex][cpu_way_c][cpuOffset];
    cpuStateOut      = state_q[cpuIndex][cpu_way_c];
    cpuConflict      = conflict_c;
    snoopHit         = snoop_hit_c;
    snoopCacheNumber = snoop_way_c;
    snoopStateOut    = snoop_hit_c ? state_q[snoopIndex][snoop_way_c] : INV;
  end

  // Storage update; the snoop state write is applied last so it wins a collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]   <= '0;
          state_q[s][w] <= INV;
          age_q[s][w]   <= SET_ASSOCIATIVITY'(w);
          for (int o = 0; o < WORDS; o++) begin
            data_q[s][w][o] <= '0;
          end
        end
      end
    end else begin
      if (cpuWriteData) begin
        data_q[cpuIndex][cpu_way_c][cpuOffset] <= cpuDataIn;
      end
      if (!conflict_c) begin
        if (cpuWriteTag)   tag_q[cpuIndex][cpu_way_c]   <= cpuTagIn;
        if (cpuWriteState) state_q[cpuIndex][cpu_way_c] <= cpuStateIn;
      end
      if (snoop_we_c) begin
        state_q[snoopIndex][snoop_way_c] <= snoopStateIn;
      end
      if (lru_en_c) begin
        for (int w = 0; w < WAYS; w++) begin
          if (SET_ASSOCIATIVITY'(w) == cpu_way_c) begin
            age_q[cpuIndex][w] <= '0;
          end else if (age_q[cpuIndex][w] < acc_age_c) begin
            age_q[cpuIndex][w] <= age_q[cpuIndex][w] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_port_snoopy_cache_unit.sv
// Directed bench for dual_port_snoopy_cache_unit with hand-computed expectations.
module tb_dual_port_snoopy_cache_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  cpuIndex, cpuTagIn, snoopIndex, snoopTagIn;
  logic [3:0]  cpuOffset;
  logic        cpuAccessEnable, cpuWriteData, cpuWriteState, cpuWriteTag;
  logic [15:0] cpuDataIn, cpuDataOut;
  logic [1:0]  cpuStateIn, cpuStateOut, snoopStateIn, snoopStateOut;
  logic        cpuHit, cpuConflict, snoopHit, snoopWriteState;
  logic [1:0]  cpuCacheNumber, snoopCacheNumber;

  int n_cmp = 0;
  int n_err = 0;

  dual_port_snoopy_cache_unit dut (
    .clock(clock), .reset(reset),
    .cpuIndex(cpuIndex), .cpuOffset(cpuOffset), .cpuTagIn(cpuTagIn),
    .cpuAccessEnable(cpuAccessEnable), .cpuDataIn(cpuDataIn), .cpuWriteData(cpuWriteData),
    .cpuStateIn(cpuStateIn), .cpuWriteState(cpuWriteState), .cpuWriteTag(cpuWriteTag),
    .cpuHit(cpuHit), .cpuCacheNumber(cpuCacheNumber), .cpuDataOut(cpuDataOut),
    .cpuStateOut(cpuStateOut), .cpuConflict(cpuConflict),
    .snoopIndex(snoopIndex), .snoopTagIn(snoopTagIn), .snoopStateIn(snoopStateIn),
    .snoopWriteState(snoopWriteState), .snoopHit(snoopHit),
    .snoopCacheNumber(snoopCacheNumber), .snoopStateOut(snoopStateOut)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cpuAccessEnable = 1'b0; cpuWriteData = 1'b0; cpuWriteState = 1'b0;
    cpuWriteTag = 1'b0; snoopWriteState = 1'b0;
    cpuDataIn = '0; cpuStateIn = '0; snoopStateIn = '0;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic cpu_at(input logic [5:0] idx, input logic [5:0] tg, input logic [3:0] off);
    cpuIndex = idx; cpuTagIn = tg; cpuOffset = off;
  endtask

  task automatic snoop_at(input logic [5:0] idx, input logic [5:0] tg);
    snoopIndex = idx; snoopTagIn = tg;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cpuHit"},     32'(cpuHit), 32'h0);
    chk({pfx, "_cpuNum"},     32'(cpuCacheNumber), 32'h0);
    chk({pfx, "_cpuData"},    32'(cpuDataOut), 32'h0);
    chk({pfx, "_cpuState"},   32'(cpuStateOut), 32'h0);
    chk({pfx, "_conflict"},   32'(cpuConflict), 32'h0);
    chk({pfx, "_snoopHit"},   32'(snoopHit), 32'h0);
    chk({pfx, "_snoopNum"},   32'(snoopCacheNumber), 32'h0);
    chk({pfx, "_snoopState"}, 32'(snoopStateOut), 32'h0);
  endtask

  logic [5:0] fill_tags [4];
  logic [1:0] fill_ways [4];

  initial begin
    reset = 1'b1;
    idle();
    cpu_at(6'd3, 6'h05, 4'd0);
    snoop_at(6'd3, 6'h05);
    #2;
    chk_reset_outputs("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    // allocate tag 5 into index 3 with state 1
    cpuWriteTag = 1'b1; cpuWriteState = 1'b1; cpuStateIn = 2'd1; cpuAccessEnable = 1'b1;
    #1;
    chk("alloc5_miss", 32'(cpuHit), 32'h0);
    chk("alloc5_victim", 32'(cpuCacheNumber), 32'h0);
    cycle();
    #1;
    chk("hit5", 32'(cpuHit), 32'h1);
    chk("hit5_way", 32'(cpuCacheNumber), 32'h0);
    chk("hit5_state", 32'(cpuStateOut), 32'h1);
    chk("snoop5_hit", 32'(snoopHit), 32'h1);
    chk("snoop5_way", 32'(snoopCacheNumber), 32'h0);
    chk("snoop5_state", 32'(snoopStateOut), 32'h1);

    // clear way 0 via snoop, then fill set 3 with tags 1..4
    snoopWriteState = 1'b1; snoopStateIn = 2'd0;
    cycle();
    for (int t = 0; t < 4; t++) begin
      cpu_at(6'd3, 6'(t + 1), 4'd0);
      cpuWriteTag = 1'b1; cpuWriteState = 1'b1; cpuStateIn = 2'd1; cpuAccessEnable = 1'b1;
      #1;
      chk("fill_victim", 32'(cpuCacheNumber), 32'(t));
      cycle();
    end
    // touching tag 1 leaves way 1 oldest
    cpu_at(6'd3, 6'h01, 4'd0); cpuAccessEnable = 1'b1;
    #1;
    chk("touch1_way", 32'(cpuCacheNumber), 32'h0);
    cycle();
    cpu_at(6'd3, 6'h09, 4'd0);
    #1;
    chk("miss9_hit", 32'(cpuHit), 32'h0);
    chk("miss9_victim", 32'(cpuCacheNumber), 32'h1);
    cpuWriteTag = 1'b1; cpuWriteState = 1'b1; cpuStateIn = 2'd1; cpuAccessEnable = 1'b1;
    cycle();
    #1;
    chk("hit9", 32'(cpuHit), 32'h1);
    chk("hit9_way", 32'(cpuCacheNumber), 32'h1);

    // data write to way 2 (tag 3) offset 7
    cpu_at(6'd3, 6'h03, 4'd7); cpuWriteData = 1'b1; cpuDataIn = 16'hBEEF;
    #1;
    chk("wr_way", 32'(cpuCacheNumber), 32'h2);
    chk("wr_old_data", 32'(cpuDataOut), 32'h0);
    cycle();
    #1;
    chk("rd_off7", 32'(cpuDataOut), 32'hBEEF);
    cpuOffset = 4'd6;
    #1;
    chk("rd_off6", 32'(cpuDataOut), 32'h0);

    // snoop write to an absent tag changes nothing
    snoop_at(6'd3, 6'h02); snoopWriteState = 1'b1; snoopStateIn = 2'd0;
    #1;
    chk("snoop2_hit", 32'(snoopHit), 32'h0);
    chk("snoop2_way", 32'(snoopCacheNumber), 32'h0);
    chk("snoop2_state", 32'(snoopStateOut), 32'h0);
    cycle();
    fill_tags[0] = 6'h01; fill_tags[1] = 6'h09; fill_tags[2] = 6'h03; fill_tags[3] = 6'h04;
    fill_ways[0] = 2'd0;  fill_ways[1] = 2'd1;  fill_ways[2] = 2'd2;  fill_ways[3] = 2'd3;
    for (int i = 0; i < 4; i++) begin
      cpu_at(6'd3, fill_tags[i], 4'd0);
      #1;
      chk("still_hit", 32'(cpuHit), 32'h1);
      chk("still_way", 32'(cpuCacheNumber), 32'(fill_ways[i]));
    end

    // snoop invalidate tag 9 (way 1)
    snoop_at(6'd3, 6'h09);
    #1;
    chk("snoop9_hit", 32'(snoopHit), 32'h1);
    chk("snoop9_way", 32'(snoopCacheNumber), 32'h1);
    snoopWriteState = 1'b1; snoopStateIn = 2'd0;
    cycle();
    cpu_at(6'd3, 6'h09, 4'd0);
    #1;
    chk("inv9_miss", 32'(cpuHit), 32'h0);
    chk("inv9_victim", 32'(cpuCacheNumber), 32'h1);

    // collision on index 3 way 0: snoop wins, data write still lands
    cpu_at(6'd3, 6'h01, 4'd0);
    cpuWriteState = 1'b1; cpuStateIn = 2'd2; cpuWriteData = 1'b1; cpuDataIn = 16'h1234;
    snoop_at(6'd3, 6'h01); snoopWriteState = 1'b1; snoopStateIn = 2'd0;
    #1;
    chk("coll_conflict", 32'(cpuConflict), 32'h1);
    cycle();
    #1;
    chk("coll_miss", 32'(cpuHit), 32'h0);
    chk("coll_way", 32'(cpuCacheNumber), 32'h0);
    chk("coll_state", 32'(cpuStateOut), 32'h0);
    chk("coll_data", 32'(cpuDataOut), 32'h1234);
    chk("coll_snoop_miss", 32'(snoopHit), 32'h0);

    // different index: no conflict, both writes commit
    cpu_at(6'd5, 6'h07, 4'd0);
    cpuWriteTag = 1'b1; cpuWriteState = 1'b1; cpuStateIn = 2'd1; cpuAccessEnable = 1'b1;
    cpuWriteData = 1'b1; cpuDataIn = 16'hA5A5;
    cycle();
    cpuWriteState = 1'b1; cpuStateIn = 2'd2;
    snoop_at(6'd3, 6'h03); snoopWriteState = 1'b1; snoopStateIn = 2'd0;
    #1;
    chk("diff_snoop_hit", 32'(snoopHit), 32'h1);
    chk("diff_conflict", 32'(cpuConflict), 32'h0);
    cycle();
    #1;
    chk("diff_cpu_hit", 32'(cpuHit), 32'h1);
    chk("diff_cpu_state", 32'(cpuStateOut), 32'h2);
    chk("diff_cpu_data", 32'(cpuDataOut), 32'hA5A5);
    chk("diff_snoop_inv", 32'(snoopHit), 32'h0);

    // asynchronous reset with valid lines present
    snoop_at(6'd3, 6'h04);
    #1;
    chk("pre_rst_cpu_hit", 32'(cpuHit), 32'h1);
    chk("pre_rst_snoop_hit", 32'(snoopHit), 32'h1);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_at(6'd3, fill_tags[i], 4'd0);
      #1;
      chk("post_rst_miss", 32'(cpuHit), 32'h0);
    end
    cpu_at(6'd5, 6'h07, 4'd0);
    #1;
    chk("post_rst_miss5", 32'(cpuHit), 32'h0);
    chk("post_rst_data5", 32'(cpuDataOut), 32'h0);
    chk("post_rst_snoop", 32'(snoopHit), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
